// File: rtl/and_arr_pkg.sv
// Shared definitions for the logic-built multiplexer blocks: width limits and
// a one-hot test reused by every mux that checks its select vector.
package and_arr_pkg;

    localparam int AND_ARR_WIDTH_DEF = 2;
    localparam int AND_ARR_WIDTH_MAX = 64;

    // True when exactly one of the low w bits of v is set; bits at and above w are ignored.
    function automatic logic is_onehot(logic [AND_ARR_WIDTH_MAX-1:0] v, int w);
        int cnt;
        cnt = 0;
        for (int i = 0; i < AND_ARR_WIDTH_MAX; i++) begin
            if (i < w) cnt += int'(v[i]);
        end
        return (cnt == 1);
    endfunction

endpackage

// File: rtl/and_arr_lane.sv
// One gating lane: y captures a & b whenever en is high, and is cleared by
// the synchronous reset.
module and_arr_lane (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic y
);

    // NOTE: state flops take non-blocking assignments; reset is synchronous and wins over en.
    always_ff @(posedge clk) begin
        if (rst)     y <= 1'b0;
        else if (en) y <= a & b;
    end

endmodule

// File: rtl/and_arr_param.sv
// Parameterised registered AND array: per-lane gating plus the mux OR-reduction,
// a one-hot select checker and the valid pipeline flop. All outputs come from flops.
module and_arr_param
    import and_arr_pkg::*;
#(
    parameter int WIDTH_I = AND_ARR_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH_I-1:0] in,
    input  logic [WIDTH_I-1:0] x,
    input  logic               in_valid,
    output logic [WIDTH_I-1:0] out,
    output logic               out_valid,
    output logic               mux_o,
    output logic               sel_err
);

    if (WIDTH_I < 1 || WIDTH_I > AND_ARR_WIDTH_MAX) begin : g_bad_width
        $fatal(1, "and_arr_param: WIDTH_I out of range 1..64");
    end

    for (genvar i = 0; i < WIDTH_I; i++) begin : g_lane
        and_arr_lane u_lane (
            .clk (clk),
            .rst (rst),
            .en  (in_valid),
            .a   (in[i]),
            .b   (x[i]),
            .y   (out[i])
        );
    end

    logic [WIDTH_I-1:0]           gated;
    logic [AND_ARR_WIDTH_MAX-1:0] x_ext;

    assign gated = in & x;
    assign x_ext = AND_ARR_WIDTH_MAX'(x);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            mux_o     <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                mux_o   <= |gated;
                sel_err <= ~is_onehot(x_ext, WIDTH_I);
            end
        end
    end

endmodule

// File: tb/tb_and_arr_param.sv
// Directed and randomised checks of and_arr_param at widths 2 and 8; inputs are
// driven on the falling edge and results sampled on the following falling edge.
module tb_and_arr_param;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in2, x2, out2;
    logic       v2, ov2, mux2, sel2;
    logic [7:0] in8, x8, out8;
    logic       v8, ov8, mux8, sel8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    and_arr_param #(.WIDTH_I(2)) dut2 (
        .clk(clk), .rst(rst), .in(in2), .x(x2), .in_valid(v2),
        .out(out2), .out_valid(ov2), .mux_o(mux2), .sel_err(sel2)
    );

    and_arr_param #(.WIDTH_I(8)) dut8 (
        .clk(clk), .rst(rst), .in(in8), .x(x8), .in_valid(v8),
        .out(out8), .out_valid(ov8), .mux_o(mux8), .sel_err(sel8)
    );

    // Packed view of the width-2 outputs: {out, mux_o, sel_err, out_valid}.
    function automatic logic [4:0] obs2();
        return {out2, mux2, sel2, ov2};
    endfunction

    task automatic drive2(input logic r, input logic v, input logic [1:0] d, input logic [1:0] s);
        rst = r; v2 = v; in2 = d; x2 = s;
    endtask

    task automatic test_reset();
        logic [4:0] got;
        drive2(1'b1, 1'b1, 2'b11, 2'b01);
        v8 = 1'b1; in8 = 8'hFF; x8 = 8'h01;
        repeat (2) @(negedge clk);
        got = obs2();
        checks++;
        if (got !== 5'b00_0_0_0) begin
            errors++;
            $display("FAIL reset_w2 got=%b exp=%b", got, 5'b00_0_0_0);
        end
        checks++;
        if ({out8, mux8, sel8, ov8} !== 11'd0) begin
            errors++;
            $display("FAIL reset_w8 got=%b exp=%b", {out8, mux8, sel8, ov8}, 11'd0);
        end
        v8 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0] vin [4] = '{2'b00, 2'b11, 2'b11, 2'b10};
        logic [1:0] vx  [4] = '{2'b01, 2'b01, 2'b10, 2'b11};
        logic [4:0] exp [4] = '{5'b00_0_0_1, 5'b01_1_0_1, 5'b10_1_0_1, 5'b10_1_1_1};
        logic [4:0] got;
        for (int i = 0; i < 4; i++) begin
            drive2(1'b0, 1'b1, vin[i], vx[i]);
            @(negedge clk);
            got = obs2();
            checks++;
            if (got !== exp[i]) begin
                errors++;
                $display("FAIL stream_%0d got=%b exp=%b", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_zero_sel();
        logic [4:0] got;
        drive2(1'b0, 1'b1, 2'b11, 2'b00);
        @(negedge clk);
        got = obs2();
        checks++;
        if (got !== 5'b00_0_1_1) begin
            errors++;
            $display("FAIL zero_sel got=%b exp=%b", got, 5'b00_0_1_1);
        end
    endtask

    task automatic test_hold();
        logic [4:0] got;
        drive2(1'b0, 1'b1, 2'b11, 2'b10);
        @(negedge clk);
        got = obs2();
        checks++;
        if (got !== 5'b10_1_0_1) begin
            errors++;
            $display("FAIL hold_load got=%b exp=%b", got, 5'b10_1_0_1);
        end
        drive2(1'b0, 1'b0, 2'b00, 2'b11);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            got = obs2();
            checks++;
            if (got !== 5'b10_1_0_0) begin
                errors++;
                $display("FAIL hold_%0d got=%b exp=%b", i, got, 5'b10_1_0_0);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] got;
        drive2(1'b0, 1'b1, 2'b10, 2'b11);
        @(negedge clk);
        drive2(1'b1, 1'b1, 2'b11, 2'b01);
        @(negedge clk);
        got = obs2();
        checks++;
        if (got !== 5'b00_0_0_0) begin
            errors++;
            $display("FAIL reset_mid got=%b exp=%b", got, 5'b00_0_0_0);
        end
        drive2(1'b0, 1'b0, 2'b11, 2'b01);
        @(negedge clk);
        got = obs2();
        checks++;
        if (got !== 5'b00_0_0_0) begin
            errors++;
            $display("FAIL reset_mid_drop got=%b exp=%b", got, 5'b00_0_0_0);
        end
        // First edge after reset release must accept a sample.
        drive2(1'b0, 1'b1, 2'b01, 2'b01);
        @(negedge clk);
        got = obs2();
        checks++;
        if (got !== 5'b01_1_0_1) begin
            errors++;
            $display("FAIL reset_release got=%b exp=%b", got, 5'b01_1_0_1);
        end
        v2 = 1'b0;
    endtask

    task automatic test_random_w8();
        logic [7:0] e_out = 8'h00;
        logic       e_mux = 1'b0, e_sel = 1'b0, e_ov = 1'b0;
        logic [10:0] got, exp;
        for (int i = 0; i <= 1000; i++) begin
            if (i > 0) begin
                got = {out8, mux8, sel8, ov8};
                exp = {e_out, e_mux, e_sel, e_ov};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL rand_%0d got=%b exp=%b", i, got, exp);
                end
            end
            in8 = 8'($urandom);
            x8  = (i % 3 == 0) ? 8'(1 << $urandom_range(7, 0)) : 8'($urandom);
            v8  = ($urandom_range(3, 0) != 0);
            e_ov = v8;
            if (v8) begin
                e_out = in8 & x8;
                e_mux = (e_out != 8'h00);
                e_sel = ($countones(x8) != 1);
            end
            @(negedge clk);
        end
        v8 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; v2 = 1'b0; in2 = '0; x2 = '0;
        v8 = 1'b0; in8 = '0; x8 = '0;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_zero_sel();
        test_hold();
        test_reset_mid();
        test_random_w8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
